// File: rtl/sha3_pkg.sv
// Shared SHA3 constants and the arbiter state encoding used by the
// sha3_core_arbiter slice.
package sha3_pkg;

  localparam int SHA3_RATE_W = 1088;
  localparam int SHA3_DIG_W  = 256;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_NEXT = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requester after rr_ptr (wrapping) wins.
// Purely combinational.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id
);

  logic           hi_found;
  logic           lo_found;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;

  // Requesters above rr_ptr take priority over those at or below it; the
  // descending scan leaves the lowest index of each group.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = IDW'(i);
        end
      end
    end
  end

  assign gnt_valid = hi_found | lo_found;
  assign gnt_id    = hi_found ? hi_id : lo_id;

endmodule

// File: rtl/sha3_core_arbiter.sv
// Shares one SHA3 core between N_REQ clients: round-robin grant held for a
// whole multi-block message, with a watchdog that aborts a silent core.
module sha3_core_arbiter
  import sha3_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int BLK_W   = SHA3_RATE_W,
  parameter  int DIG_W   = SHA3_DIG_W,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*BLK_W-1:0] req_block,
  input  logic [N_REQ-1:0]       req_more,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       rsp_next,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ-1:0]       rsp_err,
  output logic [DIG_W-1:0]       rsp_digest,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic [BLK_W-1:0]       core_in,
  output logic                   core_more,
  output logic                   core_in_valid,
  output logic                   core_abort,
  input  logic [DIG_W-1:0]       core_out,
  input  logic                   core_hash_next,
  input  logic                   core_out_valid,
  output arb_state_e             state_dbg
);

  localparam int WDW = $clog2(TIMEOUT);

  arb_state_e     state;
  arb_state_e     state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [WDW-1:0] wdog;
  logic           got_next;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  logic             core_wait;
  logic             done_evt;
  logic             next_evt;
  logic             expire;
  logic             owner_blk;
  logic [N_REQ-1:0] own_1h;

  logic [N_REQ-1:0] ack_d;
  logic [N_REQ-1:0] next_d;
  logic [N_REQ-1:0] valid_d;
  logic [N_REQ-1:0] err_d;
  logic             civ_d;
  logic             abort_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // The core is being waited on in WAIT_DONE, and in WAIT_NEXT until it has
  // asked for the next block; after that the owner is the one we wait for.
  assign core_wait = (state == ST_WAIT_DONE) || (state == ST_WAIT_NEXT && !got_next);
  assign done_evt  = core_wait && core_out_valid;
  assign next_evt  = (state == ST_WAIT_NEXT) && !got_next && core_hash_next && !core_out_valid;
  assign expire    = core_wait && !core_out_valid && !next_evt && (wdog == WDW'(TIMEOUT - 1));
  assign owner_blk = (state == ST_WAIT_NEXT) && got_next && req_valid[grant_id];
  assign own_1h    = N_REQ'(1) << grant_id;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = core_more ? ST_WAIT_NEXT : ST_WAIT_DONE;
      ST_WAIT_NEXT, ST_WAIT_DONE: begin
        if (done_evt || expire) state_nxt = ST_IDLE;
        else if (owner_blk)     state_nxt = ST_ISSUE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Every response and core strobe is registered, so each appears one cycle
  // after the state/event that causes it.
  always_comb begin
    ack_d   = (state == ST_ISSUE) ? own_1h : '0;
    civ_d   = (state == ST_ISSUE);
    next_d  = next_evt ? own_1h : '0;
    valid_d = done_evt ? own_1h : '0;
    err_d   = expire ? own_1h : '0;
    abort_d = expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ack       <= '0;
      rsp_next      <= '0;
      rsp_valid     <= '0;
      rsp_err       <= '0;
      rsp_digest    <= '0;
      grant_id      <= '0;
      core_in       <= '0;
      core_more     <= 1'b0;
      core_in_valid <= 1'b0;
      core_abort    <= 1'b0;
      rr_ptr        <= IDW'(N_REQ - 1);
      wdog          <= '0;
      got_next      <= 1'b0;
    end else begin
      req_ack       <= ack_d;
      rsp_next      <= next_d;
      rsp_valid     <= valid_d;
      rsp_err       <= err_d;
      core_in_valid <= civ_d;
      core_abort    <= abort_d;

      if (state == ST_IDLE && gnt_valid) begin
        core_in   <= req_block[int'(gnt_id)*BLK_W +: BLK_W];
        core_more <= req_more[gnt_id];
        grant_id  <= gnt_id;
      end else if (owner_blk) begin
        core_in   <= req_block[int'(grant_id)*BLK_W +: BLK_W];
        core_more <= req_more[grant_id];
      end

      if (state == ST_ISSUE)                            wdog <= '0;
      else if (core_wait && !core_out_valid && !next_evt && !expire) wdog <= wdog + 1'b1;

      if (state == ST_ISSUE) got_next <= 1'b0;
      else if (next_evt)     got_next <= 1'b1;

      if (done_evt)           rsp_digest <= core_out;
      if (done_evt || expire) rr_ptr     <= grant_id;
    end
  end

endmodule

// File: tb/tb_sha3_core_arbiter.sv
// Directed bench for sha3_core_arbiter: tests push hand-computed expected
// events, a negedge monitor pops and compares whatever the DUT emits.
module tb_sha3_core_arbiter;
  import sha3_pkg::*;

  localparam int N_REQ   = 2;
  localparam int BLK_W   = 1088;
  localparam int DIG_W   = 256;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 1;
  localparam int EW      = 3 + N_REQ + 1 + BLK_W;
  localparam int BUDGET  = 400;

  localparam logic [2:0] K_ISSUE = 3'd1;
  localparam logic [2:0] K_NEXT  = 3'd2;
  localparam logic [2:0] K_DONE  = 3'd3;
  localparam logic [2:0] K_ERR   = 3'd4;
  localparam logic [2:0] K_BAD   = 3'd7;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*BLK_W-1:0] req_block;
  logic [N_REQ-1:0]       req_more = '0;
  logic [N_REQ-1:0]       req_ack, rsp_next, rsp_valid, rsp_err;
  logic [DIG_W-1:0]       rsp_digest;
  logic                   busy;
  logic [IDW-1:0]         grant_id;
  logic [BLK_W-1:0]       core_in;
  logic                   core_more, core_in_valid, core_abort;
  logic [DIG_W-1:0]       core_out = '0;
  logic                   core_hash_next = 1'b0;
  logic                   core_out_valid = 1'b0;
  arb_state_e             state_dbg;

  logic [BLK_W-1:0] blk [N_REQ];
  assign req_block = {blk[1], blk[0]};

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sha3_core_arbiter #(.N_REQ(N_REQ), .BLK_W(BLK_W), .DIG_W(DIG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_block(req_block), .req_more(req_more),
    .req_ack(req_ack), .rsp_next(rsp_next), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_digest(rsp_digest), .busy(busy), .grant_id(grant_id), .core_in(core_in),
    .core_more(core_more), .core_in_valid(core_in_valid), .core_abort(core_abort),
    .core_out(core_out), .core_hash_next(core_hash_next), .core_out_valid(core_out_valid),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] mk(logic [2:0] k, logic [N_REQ-1:0] v, logic f,
                                       logic [BLK_W-1:0] d);
    return {k, v, f, d};
  endfunction

  task automatic chk(string nm, logic [BLK_W-1:0] act, logic [BLK_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act[255:0], exp[255:0]);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic sb_pop(logic [EW-1:0] obs);
    logic [EW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d vec %b flag %b data %0h, expected nothing",
               obs[EW-1 -: 3], obs[EW-4 -: N_REQ], obs[BLK_W], obs[63:0]);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        n_fail++;
        $display("FAIL sb_event: got kind %0d vec %b flag %b data %0h, expected kind %0d vec %b flag %b data %0h",
                 obs[EW-1 -: 3], obs[EW-4 -: N_REQ], obs[BLK_W], obs[63:0],
                 e[EW-1 -: 3], e[EW-4 -: N_REQ], e[BLK_W], e[63:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (core_in_valid || (|req_ack))
      sb_pop(mk(core_in_valid ? K_ISSUE : K_BAD, req_ack, core_more, core_in));
    if (|rsp_next)  sb_pop(mk(K_NEXT, rsp_next, 1'b0, '0));
    if (|rsp_valid) sb_pop(mk(K_DONE, rsp_valid, 1'b0, BLK_W'(rsp_digest)));
    if ((|rsp_err) || core_abort) sb_pop(mk(K_ERR, rsp_err, core_abort, '0));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, logic [BLK_W-1:0] b, logic m);
    blk[i]       = b;
    req_more[i]  = m;
    req_valid[i] = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      tick();
      if (req_ack[i]) break;
    end
    chk("send_ack_seen", BLK_W'(req_ack[i]), BLK_W'(1));
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_next(int i);
    for (int c = 0; c < BUDGET; c++) begin
      tick();
      if (rsp_next[i]) break;
    end
    chk("rsp_next_seen", BLK_W'(rsp_next[i]), BLK_W'(1));
  endtask

  task automatic core_wait_issue();
    for (int c = 0; c < BUDGET; c++) begin
      tick();
      if (core_in_valid) break;
    end
    chk("core_issue_seen", BLK_W'(core_in_valid), BLK_W'(1));
  endtask

  task automatic core_next_pulse();
    core_hash_next = 1'b1;
    tick();
    core_hash_next = 1'b0;
  endtask

  task automatic core_done(logic [DIG_W-1:0] d);
    core_out       = d;
    core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_req_ack"},    BLK_W'(req_ack), '0);
    chk({nm, "_rsp_next"},   BLK_W'(rsp_next), '0);
    chk({nm, "_rsp_valid"},  BLK_W'(rsp_valid), '0);
    chk({nm, "_rsp_err"},    BLK_W'(rsp_err), '0);
    chk({nm, "_rsp_digest"}, BLK_W'(rsp_digest), '0);
    chk({nm, "_busy"},       BLK_W'(busy), '0);
    chk({nm, "_grant_id"},   BLK_W'(grant_id), '0);
    chk({nm, "_core_in"},    core_in, '0);
    chk({nm, "_core_more"},  BLK_W'(core_more), '0);
    chk({nm, "_core_ivld"},  BLK_W'(core_in_valid), '0);
    chk({nm, "_core_abort"}, BLK_W'(core_abort), '0);
    chk({nm, "_state"},      BLK_W'(state_dbg), BLK_W'(ST_IDLE));
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    logic [DIG_W-1:0] da5;
    int t0;
    da5 = {32{8'hA5}};
    blk[0] = '0;
    blk[1] = '0;

    do_reset();
    chk_all_zero("reset");

    // 1: single block from req0, latency and one digest pulse
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h1111_0001)));
    exp_q.push_back(mk(K_DONE,  2'b01, 1'b0, BLK_W'(da5)));
    blk[0] = BLK_W'(64'h1111_0001);
    req_more[0] = 1'b0;
    req_valid[0] = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (req_ack[0]) break;
    end
    req_valid[0] = 1'b0;
    chk("t1_ack_latency", BLK_W'(cyc - t0), BLK_W'(2));
    chk("t1_busy", BLK_W'(busy), BLK_W'(1));
    repeat (4) tick();
    core_done(da5);
    chk("t1_rsp_valid", BLK_W'(rsp_valid), BLK_W'(2'b01));
    chk("t1_digest", BLK_W'(rsp_digest), BLK_W'(da5));
    tick();
    chk("t1_rsp_valid_once", BLK_W'(rsp_valid), '0);
    chk("t1_busy_low", BLK_W'(busy), '0);

    // 2: ties after reset go to req0, then req1; the next tie goes to req0 again
    do_reset();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h2000_0000 + 4*r)));
      exp_q.push_back(mk(K_DONE,  2'b01, 1'b0, BLK_W'(64'hD200 + 4*r)));
      exp_q.push_back(mk(K_ISSUE, 2'b10, 1'b0, BLK_W'(64'h2000_0001 + 4*r)));
      exp_q.push_back(mk(K_DONE,  2'b10, 1'b0, BLK_W'(64'hD201 + 4*r)));
      fork
        send(0, BLK_W'(64'h2000_0000 + 4*r), 1'b0);
        send(1, BLK_W'(64'h2000_0001 + 4*r), 1'b0);
        begin
          core_wait_issue(); repeat (2) tick(); core_done(DIG_W'(64'hD200 + 4*r));
          core_wait_issue(); repeat (2) tick(); core_done(DIG_W'(64'hD201 + 4*r));
        end
      join
      tick();
    end

    // 3: req1 two-block message holds the grant while req0 waits
    exp_q.push_back(mk(K_ISSUE, 2'b10, 1'b1, BLK_W'(64'h3000_000A)));
    exp_q.push_back(mk(K_NEXT,  2'b10, 1'b0, '0));
    exp_q.push_back(mk(K_ISSUE, 2'b10, 1'b0, BLK_W'(64'h3000_000B)));
    exp_q.push_back(mk(K_DONE,  2'b10, 1'b0, BLK_W'(64'hD3A)));
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h3000_000C)));
    exp_q.push_back(mk(K_DONE,  2'b01, 1'b0, BLK_W'(64'hD3C)));
    fork
      begin
        send(1, BLK_W'(64'h3000_000A), 1'b1);
        wait_next(1);
        send(1, BLK_W'(64'h3000_000B), 1'b0);
      end
      begin
        repeat (4) tick();
        send(0, BLK_W'(64'h3000_000C), 1'b0);
      end
      begin
        core_wait_issue(); repeat (2) tick(); core_next_pulse();
        core_wait_issue(); repeat (2) tick(); core_done(DIG_W'(64'hD3A));
        core_wait_issue(); repeat (2) tick(); core_done(DIG_W'(64'hD3C));
      end
    join
    tick();

    // 4a: silent core is aborted 8 cycles after the issue strobe
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h4000_000A)));
    exp_q.push_back(mk(K_ERR,   2'b01, 1'b1, '0));
    fork
      send(0, BLK_W'(64'h4000_000A), 1'b0);
      begin
        core_wait_issue();
        repeat (7) tick();
        chk("t4_no_err_early", BLK_W'(rsp_err), '0);
        tick();
        chk("t4_rsp_err", BLK_W'(rsp_err), BLK_W'(2'b01));
        chk("t4_core_abort", BLK_W'(core_abort), BLK_W'(1));
        chk("t4_idle", BLK_W'(busy), '0);
        chk("t4_digest_held", BLK_W'(rsp_digest), BLK_W'(64'hD3C));
      end
    join
    tick();

    // 4b: digest arriving in the expiry cycle completes without error
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h4000_000B)));
    exp_q.push_back(mk(K_DONE,  2'b01, 1'b0, BLK_W'(64'hD4B)));
    fork
      send(0, BLK_W'(64'h4000_000B), 1'b0);
      begin
        core_wait_issue();
        repeat (7) tick();
        core_done(DIG_W'(64'hD4B));
        chk("t4b_rsp_valid", BLK_W'(rsp_valid), BLK_W'(2'b01));
        chk("t4b_no_err", BLK_W'(rsp_err), '0);
      end
    join
    tick();

    // 5: reset in WAIT_NEXT clears outputs and restores rr_ptr
    exp_q.push_back(mk(K_ISSUE, 2'b10, 1'b1, BLK_W'(64'h5000_000A)));
    exp_q.push_back(mk(K_NEXT,  2'b10, 1'b0, '0));
    fork
      send(1, BLK_W'(64'h5000_000A), 1'b1);
      begin
        core_wait_issue(); repeat (2) tick(); core_next_pulse();
      end
    join
    rst = 1'b1;
    tick();
    chk_all_zero("t5_rst");
    rst = 1'b0;
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h5000_000B)));
    exp_q.push_back(mk(K_DONE,  2'b01, 1'b0, BLK_W'(64'hD5B)));
    exp_q.push_back(mk(K_ISSUE, 2'b10, 1'b0, BLK_W'(64'h5000_000C)));
    exp_q.push_back(mk(K_DONE,  2'b10, 1'b0, BLK_W'(64'hD5C)));
    fork
      send(0, BLK_W'(64'h5000_000B), 1'b0);
      send(1, BLK_W'(64'h5000_000C), 1'b0);
      begin
        core_wait_issue(); repeat (2) tick(); core_done(DIG_W'(64'hD5B));
        core_wait_issue(); repeat (2) tick(); core_done(DIG_W'(64'hD5C));
      end
    join
    tick();

    // 6: owner stalls 100 cycles between blocks; watchdog stays quiet
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b1, BLK_W'(64'h6000_000A)));
    exp_q.push_back(mk(K_NEXT,  2'b01, 1'b0, '0));
    exp_q.push_back(mk(K_ISSUE, 2'b01, 1'b0, BLK_W'(64'h6000_000B)));
    exp_q.push_back(mk(K_DONE,  2'b01, 1'b0, BLK_W'(64'hD6)));
    fork
      begin
        send(0, BLK_W'(64'h6000_000A), 1'b1);
        wait_next(0);
        repeat (100) tick();
        chk("t6_busy_stall", BLK_W'(busy), BLK_W'(1));
        chk("t6_state_stall", BLK_W'(state_dbg), BLK_W'(ST_WAIT_NEXT));
        send(0, BLK_W'(64'h6000_000B), 1'b0);
      end
      begin
        core_wait_issue(); repeat (2) tick(); core_next_pulse();
        core_wait_issue(); repeat (3) tick(); core_done(DIG_W'(64'hD6));
        chk("t6_digest", BLK_W'(rsp_digest), BLK_W'(64'hD6));
      end
    join

    repeat (5) tick();
    chk("sb_drained", BLK_W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
